digipot_spi_rx: RTL and testbench
=================================

Name: digipot_spi_rx

Overview:
- SPI-style slave receiver: the far end of the 3-chip-select digipot write link (shared sclk/sdi, cs1..cs3 active-low, MSB first, 8-bit words).
- Oversamples the link with the system clock, deserializes each frame and reports which chip select it targeted.
- Holds a shadow copy of the last value written to each of the three digipots.
- Used as a loopback checker on the board and as a digipot emulator for configuring the design from an external master.

Parameters:
- DATA_W, 8, bits per frame (MSB first).
- SYNC_STAGES, 2, flip-flops in each input synchronizer (minimum 2).
- RESET_VAL, 8'h80, reset value of the pot shadow registers (midscale).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-high reset.
- sclk  in  1  serial clock from the master; idles high; async to clk, at most clk/4.
- sdi  in  1  serial data; the master changes it on sclk falling edges.
- cs1  in  1  chip select for pot 1, active low.
- cs2  in  1  chip select for pot 2, active low.
- cs3  in  1  chip select for pot 3, active low.
- dout  out  DATA_W  last correctly received word.
- dest  out  2  target of the last good word: 0 = pot1, 1 = pot2, 2 = pot3.
- valid  out  1  one-clk pulse when a good frame completes.
- err  out  1  one-clk pulse when a bad frame ends.
- busy  out  1  high while a frame is in progress.
- pot1_val  out  DATA_W  shadow register for pot 1.
- pot2_val  out  DATA_W  shadow register for pot 2.
- pot3_val  out  DATA_W  shadow register for pot 3.

Behaviour:
- Reset (async, rst=1):
  - dout=0, dest=0, valid=0, err=0, busy=0.
  - pot1_val=pot2_val=pot3_val=RESET_VAL.
  - Synchronizer flops preset to 1 (idle), bit counter=0, FSM=IDLE.
- Synchronization and edge detection:
  - sclk, sdi, cs1..cs3 each pass through SYNC_STAGES flops, then one history flop.
  - An sclk rise is sync=1 with history=0.
  - A cs change is detected the same way.
- FSM states:
  - IDLE: all synced cs high.
    - Exactly one cs low: latch its index into sel_idx, clear shift register and bit counter, go to ACTIVE.
    - Two or more cs low: go to ERR_WAIT.
  - ACTIVE (busy=1):
    - Each synced sclk rise: shift_reg <= {shift_reg[DATA_W-2:0], sdi_sync}, bit counter +1.
    - Counter saturates at DATA_W+1; reaching DATA_W+1 marks overrun.
  - ACTIVE exit when all cs high:
    - Counter==DATA_W and no overrun: valid=1 for one clk; dout<=shift_reg; dest<=sel_idx; pot[sel_idx]_val<=shift_reg; go to IDLE.
    - Any other count, including 0: err=1 for one clk; dout, dest and shadows unchanged; go to IDLE.
  - ACTIVE, any other cs pattern differing from the latched one (second cs asserts, or cs swap in one cycle): go to ERR_WAIT.
  - ERR_WAIT (busy=1): ignore sclk; when all cs high, err=1 for one clk, go to IDLE.
- Latency: valid/err rise on the clk edge after the synchronized cs rise is seen. That is at most SYNC_STAGES+2 clk edges after the cs pin rises.
- An sclk rise in the same synced cycle as the cs fall is ignored; the first data bit must come on a later edge.
- sclk edges while in IDLE are ignored.
- valid and err are never high together.
- rst mid-frame aborts the frame with no valid/err pulse. After reset, a partially seen frame (cs already low) goes through the normal IDLE rules; the master must restart it.

Optional Feature:
- Macro: DIGIPOT_SPI_RX_SDO_EN.
- Defined:
  - Adds output port sdo (1 bit), reset to 0.
  - On the synced cs fall, load the addressed pot's shadow value into an out-shift register.
  - sdo = its MSB; shift left on each synced sclk fall while ACTIVE, so the master can read back the previous value during a write.
  - sdo = 0 outside ACTIVE.
- Not defined: no sdo port, no out-shift logic; behaviour otherwise identical.

Test Plan:
- Reset then idle: pot1..3_val=8'h80, valid=err=busy=0, dout=0.
- Master at clk/4 writes 8'hA5 on cs2 -> one valid pulse, dout=8'hA5, dest=1, pot2_val=8'hA5, pot1/pot3 still 8'h80.
- Back-to-back frames 8'h3C on cs1 then 8'hFF on cs3 with 2 idle clk between -> two valid pulses; pot1_val=8'h3C, pot3_val=8'hFF.
- Frame of 7 sclk pulses on cs1, then a frame of 9 pulses -> one err pulse each, no valid, pot1_val unchanged.
- cs1 and cs2 driven low together, 8 pulses of 8'h11 -> busy=1 until both release, then one err pulse, no shadow update.
- rst asserted after bit 4 of an 8'h5A frame on cs3 -> outputs return to reset values immediately, no valid/err. With DIGIPOT_SPI_RX_SDO_EN: after writing 8'hC3 to pot1, the next cs1 frame shifts out 1,1,0,0,0,0,1,1 on sdo.

Source files
------------

// File: rtl/digipot_spi_rx_if.sv
// digipot_spi_rx_if -- bundle for the 3-chip-select digipot write link.
//
// Signals:
//   sclk, sdi, cs1..cs3   serial link, driven by the master (cs active low)
//   dout, dest            last good word and the pot it targeted (0..2)
//   valid, err            one-clk pulses for a good / bad frame end
//   busy                  frame in progress
//   pot1_val..pot3_val    shadow copies of the three digipots
//   sdo                   read-back data, only with DIGIPOT_SPI_RX_SDO_EN
//
// Modports: master (link driver / consumer of results), slave (receiver).
interface digipot_spi_rx_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              sdi;
  logic              cs1;
  logic              cs2;
  logic              cs3;
  logic [DATA_W-1:0] dout;
  logic [1:0]        dest;
  logic              valid;
  logic              err;
  logic              busy;
  logic [DATA_W-1:0] pot1_val;
  logic [DATA_W-1:0] pot2_val;
  logic [DATA_W-1:0] pot3_val;
`ifdef DIGIPOT_SPI_RX_SDO_EN
  logic              sdo;

  modport master (
    output sclk, sdi, cs1, cs2, cs3,
    input  dout, dest, valid, err, busy, pot1_val, pot2_val, pot3_val, sdo
  );

  modport slave (
    input  sclk, sdi, cs1, cs2, cs3,
    output dout, dest, valid, err, busy, pot1_val, pot2_val, pot3_val, sdo
  );
`else
  modport master (
    output sclk, sdi, cs1, cs2, cs3,
    input  dout, dest, valid, err, busy, pot1_val, pot2_val, pot3_val
  );

  modport slave (
    input  sclk, sdi, cs1, cs2, cs3,
    output dout, dest, valid, err, busy, pot1_val, pot2_val, pot3_val
  );
`endif
endinterface

// File: rtl/digipot_spi_rx.sv
// digipot_spi_rx -- SPI-style slave receiver for the 3-chip-select digipot
// link. Oversamples sclk/sdi/cs1..cs3 with clk, deserializes 8-bit MSB-first
// frames, reports the target pot and keeps a shadow of each pot value.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   digipot_spi_rx_if.slave (link inputs, dout/dest/valid/err/busy,
//         pot1_val..pot3_val, and sdo when enabled)
//
// Optional feature: define DIGIPOT_SPI_RX_SDO_EN to add the sdo read-back
// output, which shifts out the addressed pot's previous value during a write.
module digipot_spi_rx #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = 8'h80
) (
  input logic             clk,
  input logic             rst,
  digipot_spi_rx_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_ERR_WAIT = 2'd2;

  localparam int              CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(DATA_W + 1);

  logic [4:0]        raw_in;
  logic [4:0]        sync_ff [SYNC_STAGES];
  logic [4:0]        sync_s;
  logic              sclk_hist;
  logic              sclk_rise;
  logic              sdi_s;
  logic [2:0]        cs_s;
  logic              one_low;
  logic [1:0]        idx_dec;

  logic [1:0]        state;
  logic [1:0]        sel_idx;
  logic [2:0]        cs_lat;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] dout_q;
  logic [1:0]        dest_q;
  logic              valid_q;
  logic              err_q;
  logic [DATA_W-1:0] pot1_q;
  logic [DATA_W-1:0] pot2_q;
  logic [DATA_W-1:0] pot3_q;

  // Bit 0 sclk, bit 1 sdi, bits 4:2 cs3..cs1 (bit 2 = cs1).
  assign raw_in = {bus.cs3, bus.cs2, bus.cs1, bus.sdi, bus.sclk};

  // Synchronizers preset to 1 so every line looks idle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '1;
      sclk_hist <= 1'b1;
    end else begin
      sync_ff[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      sclk_hist <= sync_ff[SYNC_STAGES-1][0];
    end
  end

  assign sync_s    = sync_ff[SYNC_STAGES-1];
  assign sdi_s     = sync_s[1];
  assign cs_s      = sync_s[4:2];
  assign sclk_rise = sync_s[0] & ~sclk_hist;

  // Exactly-one-low decode of the synced chip selects.
  always_comb begin
    one_low = 1'b1;
    idx_dec = 2'd0;
    case (cs_s)
      3'b110:  idx_dec = 2'd0;
      3'b101:  idx_dec = 2'd1;
      3'b011:  idx_dec = 2'd2;
      default: one_low = 1'b0;
    endcase
  end

  // Frame FSM. The bit counter saturates at DATA_W+1 so that any overrun
  // stays distinguishable from a clean DATA_W-bit frame at cs release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_idx   <= 2'd0;
      cs_lat    <= 3'b111;
      shift_reg <= '0;
      bit_cnt   <= '0;
      dout_q    <= '0;
      dest_q    <= 2'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      pot1_q    <= RESET_VAL;
      pot2_q    <= RESET_VAL;
      pot3_q    <= RESET_VAL;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_s != 3'b111) begin
            if (one_low) begin
              state     <= ST_ACTIVE;
              sel_idx   <= idx_dec;
              cs_lat    <= cs_s;
              shift_reg <= '0;
              bit_cnt   <= '0;
            end else begin
              state <= ST_ERR_WAIT;
            end
          end
        end
        ST_ACTIVE: begin
          if (cs_s == 3'b111) begin
            state <= ST_IDLE;
            if (bit_cnt == CNT_FULL) begin
              valid_q <= 1'b1;
              dout_q  <= shift_reg;
              dest_q  <= sel_idx;
              case (sel_idx)
                2'd0:    pot1_q <= shift_reg;
                2'd1:    pot2_q <= shift_reg;
                default: pot3_q <= shift_reg;
              endcase
            end else begin
              err_q <= 1'b1;
            end
          end else if (cs_s != cs_lat) begin
            state <= ST_ERR_WAIT;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[DATA_W-2:0], sdi_s};
            if (bit_cnt != CNT_OVR) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_ERR_WAIT: begin
          if (cs_s == 3'b111) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DIGIPOT_SPI_RX_SDO_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] out_sr;
  logic [DATA_W-1:0] load_val;

  assign sclk_fall = ~sync_s[0] & sclk_hist;

  always_comb begin
    case (idx_dec)
      2'd1:    load_val = pot2_q;
      2'd2:    load_val = pot3_q;
      default: load_val = pot1_q;
    endcase
  end

  // The leading sclk fall (before any rise) only sets up the master's first
  // bit, so the MSB must stay on sdo until the first rise has been counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sr <= '0;
    end else if (state == ST_IDLE && one_low) begin
      out_sr <= load_val;
    end else if (state == ST_ACTIVE && sclk_fall && bit_cnt != '0) begin
      out_sr <= {out_sr[DATA_W-2:0], 1'b0};
    end
  end

  assign bus.sdo = (state == ST_ACTIVE) ? out_sr[DATA_W-1] : 1'b0;
`endif

  assign bus.dout     = dout_q;
  assign bus.dest     = dest_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.pot1_val = pot1_q;
  assign bus.pot2_val = pot2_q;
  assign bus.pot3_val = pot3_q;

endmodule

// File: tb/tb_digipot_spi_rx.sv
// tb_digipot_spi_rx -- directed self-checking bench for digipot_spi_rx.
// Drives the link as a master at clk/4, counts valid/err pulses and compares
// results against hand-computed values. Define DIGIPOT_SPI_RX_SDO_EN to also
// exercise the sdo read-back path.
module tb_digipot_spi_rx;

  logic clk;
  logic rst;

  digipot_spi_rx_if #(.DATA_W(8)) bus ();

  digipot_spi_rx #(
    .DATA_W(8),
    .SYNC_STAGES(2),
    .RESET_VAL(8'h80)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vecCount  = 0;
  int missCount = 0;
  int validCnt  = 0;
  int errCnt    = 0;
  int bothCnt   = 0;
  int v0;
  int e0;
  logic [15:0] readBack;

  // 50 MHz system clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse counters sampled on the inactive edge; one-clk pulses count once.
  always @(negedge clk) begin
    if (bus.valid) validCnt++;
    if (bus.err) errCnt++;
    if (bus.valid && bus.err) bothCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends nBits of data (MSB first) with the cs lines in csMask held low.
  // sclk half period is 40 ns (clk/4); sdi changes on the falling edge.
  // With doRelease the busy flag is checked before the chip selects rise.
  task automatic applyStimulus(input logic [2:0] csMask, input logic [15:0] data,
                               input int nBits, input bit doRelease);
    {bus.cs3, bus.cs2, bus.cs1} = ~csMask;
    #80;
    for (int i = nBits - 1; i >= 0; i--) begin
      bus.sclk = 1'b0;
      bus.sdi  = data[i];
      #40;
      bus.sclk = 1'b1;
      #40;
`ifdef DIGIPOT_SPI_RX_SDO_EN
      readBack = {readBack[14:0], bus.sdo};
`endif
    end
    if (doRelease) begin
      #40;
      checkOutput("busy_in_frame", 32'(bus.busy), 32'd1);
      {bus.cs3, bus.cs2, bus.cs1} = 3'b111;
      #40;
    end
  endtask

  task automatic markPulses();
    v0 = validCnt;
    e0 = errCnt;
  endtask

  task automatic checkPulses(input string tag, input int expValid, input int expErr);
    checkOutput({tag, "_valid"}, 32'(validCnt - v0), 32'(expValid));
    checkOutput({tag, "_err"}, 32'(errCnt - e0), 32'(expErr));
  endtask

  initial begin
    rst      = 1'b1;
    bus.sclk = 1'b1;
    bus.sdi  = 1'b0;
    bus.cs1  = 1'b1;
    bus.cs2  = 1'b1;
    bus.cs3  = 1'b1;
    readBack = '0;
    #35;
    checkOutput("rst_pot1", 32'(bus.pot1_val), 32'h80);
    checkOutput("rst_pot2", 32'(bus.pot2_val), 32'h80);
    checkOutput("rst_pot3", 32'(bus.pot3_val), 32'h80);
    checkOutput("rst_dout", 32'(bus.dout), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #100;
    checkOutput("idle_valid", 32'(bus.valid), 32'd0);
    checkOutput("idle_err", 32'(bus.err), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_dest", 32'(bus.dest), 32'd0);

    // sclk toggling with no chip select must be ignored.
    markPulses();
    for (int i = 0; i < 4; i++) begin
      bus.sclk = 1'b0;
      #40;
      bus.sclk = 1'b1;
      #40;
    end
    #200;
    checkPulses("idle_sclk", 0, 0);
    checkOutput("idle_sclk_busy", 32'(bus.busy), 32'd0);

    // 8'hA5 to pot 2.
    markPulses();
    applyStimulus(3'b010, 16'h00A5, 8, 1'b1);
    #200;
    checkPulses("a5", 1, 0);
    checkOutput("a5_dout", 32'(bus.dout), 32'hA5);
    checkOutput("a5_dest", 32'(bus.dest), 32'd1);
    checkOutput("a5_pot2", 32'(bus.pot2_val), 32'hA5);
    checkOutput("a5_pot1", 32'(bus.pot1_val), 32'h80);
    checkOutput("a5_pot3", 32'(bus.pot3_val), 32'h80);
    checkOutput("a5_busy_after", 32'(bus.busy), 32'd0);

    // Back-to-back: 8'h3C on cs1, 2 idle clk, 8'hFF on cs3.
    markPulses();
    applyStimulus(3'b001, 16'h003C, 8, 1'b1);
    applyStimulus(3'b100, 16'h00FF, 8, 1'b1);
    #200;
    checkPulses("b2b", 2, 0);
    checkOutput("b2b_pot1", 32'(bus.pot1_val), 32'h3C);
    checkOutput("b2b_pot3", 32'(bus.pot3_val), 32'hFF);
    checkOutput("b2b_pot2", 32'(bus.pot2_val), 32'hA5);
    checkOutput("b2b_dout", 32'(bus.dout), 32'hFF);
    checkOutput("b2b_dest", 32'(bus.dest), 32'd2);

    // Short (7) and long (9) frames on cs1.
    markPulses();
    applyStimulus(3'b001, 16'h0055, 7, 1'b1);
    #200;
    checkPulses("short", 0, 1);
    checkOutput("short_pot1", 32'(bus.pot1_val), 32'h3C);
    markPulses();
    applyStimulus(3'b001, 16'h01AB, 9, 1'b1);
    #200;
    checkPulses("long", 0, 1);
    checkOutput("long_pot1", 32'(bus.pot1_val), 32'h3C);
    checkOutput("long_dout", 32'(bus.dout), 32'hFF);
    checkOutput("long_dest", 32'(bus.dest), 32'd2);

    // cs1 and cs2 together.
    markPulses();
    applyStimulus(3'b011, 16'h0011, 8, 1'b1);
    #200;
    checkPulses("dual", 0, 1);
    checkOutput("dual_pot1", 32'(bus.pot1_val), 32'h3C);
    checkOutput("dual_pot2", 32'(bus.pot2_val), 32'hA5);
    checkOutput("dual_busy_after", 32'(bus.busy), 32'd0);

    // Reset after 4 bits of 8'h5A on cs3.
    markPulses();
    applyStimulus(3'b100, 16'h0005, 4, 1'b0);
    #20;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_dout", 32'(bus.dout), 32'h0);
    checkOutput("midrst_dest", 32'(bus.dest), 32'd0);
    checkOutput("midrst_pot1", 32'(bus.pot1_val), 32'h80);
    checkOutput("midrst_pot2", 32'(bus.pot2_val), 32'h80);
    checkOutput("midrst_pot3", 32'(bus.pot3_val), 32'h80);
    #19;
    {bus.cs3, bus.cs2, bus.cs1} = 3'b111;
    #80;
    rst = 1'b0;
    #200;
    checkPulses("midrst", 0, 0);
    checkOutput("midrst_busy_after", 32'(bus.busy), 32'd0);

`ifdef DIGIPOT_SPI_RX_SDO_EN
    // Write 8'hC3 to pot 1, then read it back on sdo during the next write.
    markPulses();
    applyStimulus(3'b001, 16'h00C3, 8, 1'b1);
    #200;
    readBack = '0;
    applyStimulus(3'b001, 16'h0000, 8, 1'b1);
    #200;
    checkPulses("sdo", 2, 0);
    checkOutput("sdo_readback", 32'(readBack[7:0]), 32'hC3);
    checkOutput("sdo_pot1", 32'(bus.pot1_val), 32'h00);
    checkOutput("sdo_idle", 32'(bus.sdo), 32'd0);
`endif

    checkOutput("never_both", 32'(bothCnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
